// File: rtl/dlx_pkg.sv
// Shared DLX definitions: the request-class code for memory writes, the
// store size codes carried on aluoperation, and the store-unit FSM state
// encoding.
package dlx_pkg;

    // Request class on aluopselect that marks a store.
    localparam logic [2:0] MEM_WRITE = 3'b100;

    // Store size codes carried on aluoperation.
    localparam logic [2:0] STOREBYTE = 3'b000;
    localparam logic [2:0] STOREHALF = 3'b001;
    localparam logic [2:0] STOREWORD = 3'b011;

    // Store unit FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } store_state_e;

endpackage

// File: rtl/dlx_store_lane_align.sv
// Byte-lane formatter for DLX stores (little-endian). This block is purely
// combinational. It replicates the source data across the lanes and builds
// the byte enables from the low address bits. It also word-aligns the
// address and reports whether the size/address pair may be issued.
//
// Optional macro DLX_STORE_ALIGN_CHECK_EN makes the block flag misaligned
// halfword and word stores as illegal. When the macro is not defined, the
// low address bits below the access size are ignored.
module dlx_store_lane_align
    import dlx_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [2:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           data,
    output logic [ADDR_WIDTH-1:0] word_addr,
    output logic [31:0]           wdata,
    output logic [3:0]            be,
    output logic                  legal
);

`ifdef DLX_STORE_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};

    // Select lane replication and byte enables for the requested store size.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wdata = '0;
        be    = '0;
        legal = 1'b0;
        case (size)
            STOREBYTE: begin
                wdata = {4{data[7:0]}};
                be    = 4'b0001 << addr[1:0];
                legal = 1'b1;
            end
            STOREHALF: begin
                wdata = {2{data[15:0]}};
                be    = addr[1] ? 4'b1100 : 4'b0011;
                legal = !(ALIGN_CHECK && addr[0]);
            end
            STOREWORD: begin
                wdata = data;
                be    = 4'b1111;
                legal = !(ALIGN_CHECK && (addr[1:0] != 2'b00));
            end
            default: begin
                // An undefined size is never issued to memory.
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dlx_store_unit.sv
// DLX store unit. The unit accepts one store at a time and formats it onto
// the byte lanes. It then holds a data-memory write request until mem_ack
// arrives or ACK_TIMEOUT cycles pass. A one-cycle st_done or st_err pulse
// reports the outcome. Reset is synchronous and active-low.
//
// Optional macro DLX_STORE_ALIGN_CHECK_EN, which is honoured in
// dlx_store_lane_align, rejects misaligned halfword and word stores.
module dlx_store_unit
    import dlx_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            aluopselect,
    input  logic [2:0]            aluoperation,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [31:0]           st_data,
    output logic                  st_ready,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    output logic                  st_done,
    output logic                  st_err
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    store_state_e          state;
    logic [CNT_W-1:0]      wait_cnt;

    logic [ADDR_WIDTH-1:0] fmt_addr;
    logic [31:0]           fmt_wdata;
    logic [3:0]            fmt_be;
    logic                  fmt_legal;
    logic                  accept;

    dlx_store_lane_align #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane_align (
        .size      (aluoperation),
        .addr      (st_addr),
        .data      (st_data),
        .word_addr (fmt_addr),
        .wdata     (fmt_wdata),
        .be        (fmt_be),
        .legal     (fmt_legal)
    );

    assign st_ready = (state == IDLE);
    assign accept   = enable && (aluopselect == MEM_WRITE) && (state == IDLE);

    // Store FSM: the request, completion and error outputs are all registered here.
    always_ff @(posedge clk) begin
        // NOTE: all state and outputs use non-blocking assignments so that every flop samples pre-edge values.
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
        end else begin
            st_done <= 1'b0;
            st_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (fmt_legal) begin
                            state     <= REQ;
                            wait_cnt  <= '0;
                            mem_req   <= 1'b1;
                            mem_addr  <= fmt_addr;
                            mem_wdata <= fmt_wdata;
                            mem_be    <= fmt_be;
                        end else begin
                            state  <= ERR;
                            st_err <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // An acknowledge wins over a timeout that expires in the same cycle.
                    if (mem_ack || (wait_cnt == CNT_LAST)) begin
                        state     <= mem_ack ? DONE : ERR;
                        st_done   <= mem_ack;
                        st_err    <= !mem_ack;
                        wait_cnt  <= '0;
                        mem_req   <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_be    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dlx_store_unit.sv
// Directed self-checking bench for dlx_store_unit. The expected values are
// hand-computed. Inputs are driven and outputs sampled 1 ns after each
// rising clock edge.
module tb_dlx_store_unit;
    import dlx_pkg::*;

    localparam int ADDR_WIDTH  = 32;
    localparam int ACK_TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    logic [2:0]            aluopselect;
    logic [2:0]            aluoperation;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [31:0]           st_data;
    logic                  st_ready;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ack;
    logic                  st_done;
    logic                  st_err;

    int n_checks = 0;
    int n_fail   = 0;

    dlx_store_unit #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .aluopselect (aluopselect),
        .aluoperation(aluoperation),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .mem_ack     (mem_ack),
        .st_done     (st_done),
        .st_err      (st_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle.
    task automatic issue(input logic [2:0] sel, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
        enable       = 1'b1;
        aluopselect  = sel;
        aluoperation = op;
        st_addr      = addr;
        st_data      = data;
        tick();
        enable = 1'b0;
    endtask

    // Full store with an acknowledge after ack_delay extra REQ cycles.
    task automatic do_store(input string tag, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_be, input int ack_delay);
        issue(MEM_WRITE, op, addr, data);
        check({tag, "_req"},   64'(mem_req),   64'd1);
        check({tag, "_rdy"},   64'(st_ready),  64'd0);
        check({tag, "_addr"},  64'(mem_addr),  64'(exp_addr));
        check({tag, "_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
        check({tag, "_be"},    64'(mem_be),    64'(exp_be));
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            check({tag, "_hold_wdata"}, 64'(mem_wdata), 64'(exp_wdata));
            check({tag, "_hold_req"},   64'(mem_req),   64'd1);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check({tag, "_done"},      64'(st_done),   64'd1);
        check({tag, "_noerr"},     64'(st_err),    64'd0);
        check({tag, "_req_drop"},  64'(mem_req),   64'd0);
        check({tag, "_wdata_clr"}, 64'(mem_wdata), 64'd0);
        check({tag, "_be_clr"},    64'(mem_be),    64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(st_done),  64'd0);
        check({tag, "_idle"},       64'(st_ready), 64'd1);
    endtask

    initial begin
        int n;
        reset        = 1'b0;
        enable       = 1'b0;
        aluopselect  = 3'b000;
        aluoperation = 3'b000;
        st_addr      = '0;
        st_data      = '0;
        mem_ack      = 1'b0;

        tick();
        tick();
        check("rst_ready", 64'(st_ready),  64'd1);
        check("rst_req",   64'(mem_req),   64'd0);
        check("rst_addr",  64'(mem_addr),  64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_be",    64'(mem_be),    64'd0);
        check("rst_done",  64'(st_done),   64'd0);
        check("rst_err",   64'(st_err),    64'd0);
        reset = 1'b1;
        tick();

        // Byte, half and word formatting.
        do_store("sb3",  STOREBYTE, 32'h0000_1003, 32'h0000_00A5, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000, 2);
        do_store("sb1",  STOREBYTE, 32'h0000_1001, 32'hFFFF_FF3C, 32'h0000_1000, 32'h3C3C_3C3C, 4'b0010, 0);
        do_store("sh2",  STOREHALF, 32'h0000_2002, 32'h1234_BEEF, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 0);
        do_store("sh0",  STOREHALF, 32'h0000_2000, 32'h0000_5A69, 32'h0000_2000, 32'h5A69_5A69, 4'b0011, 1);
        do_store("sw",   STOREWORD, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 0);

        // Misaligned word store.
`ifdef DLX_STORE_ALIGN_CHECK_EN
        issue(MEM_WRITE, STOREWORD, 32'h0000_4002, 32'hCAFE_F00D);
        check("mis_err", 64'(st_err),  64'd1);
        check("mis_req", 64'(mem_req), 64'd0);
        tick();
        check("mis_idle", 64'(st_ready), 64'd1);
`else
        do_store("mis", STOREWORD, 32'h0000_4002, 32'hCAFE_F00D, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 0);
`endif

        // Undefined size on an accepted store.
        issue(MEM_WRITE, 3'b010, 32'h0000_6000, 32'h1111_2222);
        check("badop_err",  64'(st_err),  64'd1);
        check("badop_done", 64'(st_done), 64'd0);
        check("badop_req",  64'(mem_req), 64'd0);
        tick();
        check("badop_pulse", 64'(st_err),   64'd0);
        check("badop_idle",  64'(st_ready), 64'd1);

        // Timeout: mem_ack is never asserted.
        issue(MEM_WRITE, STOREWORD, 32'h0000_5000, 32'h0BAD_0BAD);
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        check("to_cycles", 64'(n),        64'(ACK_TIMEOUT));
        check("to_err",    64'(st_err),   64'd1);
        check("to_done",   64'(st_done),  64'd0);
        check("to_be_clr", 64'(mem_be),   64'd0);
        tick();
        check("to_pulse", 64'(st_err),   64'd0);
        check("to_idle",  64'(st_ready), 64'd1);

        // Acknowledge in the last allowed cycle wins over the timeout.
        issue(MEM_WRITE, STOREWORD, 32'h0000_7000, 32'h7777_7777);
        for (int i = 0; i < ACK_TIMEOUT - 1; i++) tick();
        check("pri_req_held", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("pri_done", 64'(st_done), 64'd1);
        check("pri_err",  64'(st_err),  64'd0);
        tick();

        // mem_ack is ignored while idle.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_done",  64'(st_done),  64'd0);
        check("idle_ack_ready", 64'(st_ready), 64'd1);

        // Reset while a request is in flight.
        issue(MEM_WRITE, STOREWORD, 32'h0000_8000, 32'h8888_8888);
        tick();
        check("mid_req", 64'(mem_req), 64'd1);
        reset = 1'b0;
        tick();
        check("mid_rst_req",   64'(mem_req),  64'd0);
        check("mid_rst_done",  64'(st_done),  64'd0);
        check("mid_rst_err",   64'(st_err),   64'd0);
        check("mid_rst_ready", 64'(st_ready), 64'd1);
        reset = 1'b1;
        tick();
        check("post_rst_done", 64'(st_done), 64'd0);
        check("post_rst_err",  64'(st_err),  64'd0);

        // A request class other than MEM_WRITE is not accepted.
        issue(3'b101, STOREWORD, 32'h0000_9000, 32'h9999_9999);
        check("cls_ready", 64'(st_ready), 64'd1);
        check("cls_req",   64'(mem_req),  64'd0);
        check("cls_err",   64'(st_err),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
